// File: rtl/chipid_arbiter_cache.sv
`default_nettype none
// ============================================================================
// Module   : chipid_arbiter_cache
// Purpose  : Acquires a 64-bit chip ID from an external source (reset pulse,
//            wait for valid with timeout) and caches it. Two Avalon-MM read
//            slaves share the cache through a round-robin arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module chipid_arbiter_cache #(
  parameter int SRC_RESET_CYCLES = 4,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] src_chip_id,
  input  logic        src_data_valid,
  output logic        src_reset,
  input  logic        refresh,
  input  logic [1:0]  s0_address,
  input  logic        s0_read,
  output logic [31:0] s0_readdata,
  output logic        s0_waitrequest,
  input  logic [1:0]  s1_address,
  input  logic        s1_read,
  output logic [31:0] s1_readdata,
  output logic        s1_waitrequest,
  output logic        id_ready,
  output logic        id_error
);

  localparam logic [7:0]  c_RST_LAST = 8'(SRC_RESET_CYCLES - 1);
  localparam logic [15:0] c_TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RST_SRC    = 2'd0,
    ST_WAIT_VALID = 2'd1,
    ST_READY      = 2'd2,
    ST_ERROR      = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_rst_cnt;
  logic [7:0]  w_rst_cnt_nxt;
  logic [15:0] r_tcnt;
  logic [15:0] w_tcnt_nxt;
  logic [63:0] r_cache;
  logic [63:0] w_cache_nxt;
  logic        r_id_ready;
  logic        r_id_error;
  logic        r_last_s1;   // 1: s1 was granted most recently

  logic        w_id_valid;
  logic        w_elig0;
  logic        w_elig1;
  logic        w_gnt0;
  logic        w_gnt1;

  // Selects the 32-bit word presented at a given register address.
  function automatic logic [31:0] f_rdata(input logic [1:0]  a,
                                          input logic [63:0] cache,
                                          input logic        err,
                                          input logic        rdy);
    logic [31:0] d;
    case (a)
      2'd0:    d = cache[31:0];
      2'd1:    d = cache[63:32];
      2'd2:    d = {30'b0, err, rdy};
      default: d = 32'h0;
    endcase
    return d;
  endfunction

  // State, counters, cache, status flags and arbitration pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_RST_SRC;
      r_rst_cnt  <= 8'd0;
      r_tcnt     <= 16'd0;
      r_cache    <= 64'd0;
      r_id_ready <= 1'b0;
      r_id_error <= 1'b0;
      r_last_s1  <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_rst_cnt  <= w_rst_cnt_nxt;
      r_tcnt     <= w_tcnt_nxt;
      r_cache    <= w_cache_nxt;
      r_id_ready <= (w_state_nxt == ST_READY);
      r_id_error <= (w_state_nxt == ST_ERROR);
      if (w_gnt0)
        r_last_s1 <= 1'b0;
      else if (w_gnt1)
        r_last_s1 <= 1'b1;
    end
  end

  // Acquisition sequencing: source reset pulse, wait for valid or timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_rst_cnt_nxt = r_rst_cnt;
    w_tcnt_nxt    = r_tcnt;
    w_cache_nxt   = r_cache;
    case (r_state)
      ST_RST_SRC: begin
        if (r_rst_cnt == c_RST_LAST) begin
          w_state_nxt   = ST_WAIT_VALID;
          w_rst_cnt_nxt = 8'd0;
          w_tcnt_nxt    = 16'd0;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + 8'd1;
        end
      end
      ST_WAIT_VALID: begin
        w_tcnt_nxt = r_tcnt + 16'd1;
        // A valid ID wins over a simultaneous timeout.
        if (src_data_valid) begin
          w_cache_nxt = src_chip_id;
          w_state_nxt = ST_READY;
        end else if (r_tcnt == c_TO_LAST) begin
          w_cache_nxt = 64'd0;
          w_state_nxt = ST_ERROR;
        end
      end
      ST_READY, ST_ERROR: begin
        // Re-acquire keeps the old ID cached until a new one arrives.
        if (refresh) begin
          w_state_nxt   = ST_RST_SRC;
          w_rst_cnt_nxt = 8'd0;
        end
      end
      default: w_state_nxt = ST_RST_SRC;
    endcase
  end

  // Round-robin grant among slaves whose read can be answered this cycle.
  always_comb begin
    w_id_valid = (r_state == ST_READY) || (r_state == ST_ERROR);
    w_elig0    = s0_read && (s0_address[1] || w_id_valid);
    w_elig1    = s1_read && (s1_address[1] || w_id_valid);
    w_gnt0     = w_elig0 && (!w_elig1 || r_last_s1);
    w_gnt1     = w_elig1 && (!w_elig0 || !r_last_s1);
  end

  // Slave handshakes; data is driven only to the granted slave.
  always_comb begin
    s0_waitrequest = s0_read && !w_gnt0;
    s1_waitrequest = s1_read && !w_gnt1;
    s0_readdata    = w_gnt0 ? f_rdata(s0_address, r_cache, r_id_error, r_id_ready) : 32'h0;
    s1_readdata    = w_gnt1 ? f_rdata(s1_address, r_cache, r_id_error, r_id_ready) : 32'h0;
  end

  assign src_reset = (r_state == ST_RST_SRC);
  assign id_ready  = r_id_ready;
  assign id_error  = r_id_error;

endmodule
`default_nettype wire

// File: tb/tb_chipid_arbiter_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_chipid_arbiter_cache
// Purpose  : Directed, self-checking bench for chipid_arbiter_cache.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chipid_arbiter_cache;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] src_chip_id;
  logic        src_data_valid;
  logic        src_reset;
  logic        refresh;
  logic [1:0]  s0_address;
  logic        s0_read;
  logic [31:0] s0_readdata;
  logic        s0_waitrequest;
  logic [1:0]  s1_address;
  logic        s1_read;
  logic [31:0] s1_readdata;
  logic        s1_waitrequest;
  logic        id_ready;
  logic        id_error;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [63:0] c_ID_A = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] c_ID_B = 64'hFFFF_0000_1234_5678;
  localparam logic [63:0] c_ID_C = 64'hDEAD_BEEF_CAFE_F00D;

  typedef struct {
    logic        r0;
    logic [1:0]  a0;
    logic        r1;
    logic [1:0]  a1;
    logic [31:0] rd0;
    logic        w0;
    logic [31:0] rd1;
    logic        w1;
  } vec_t;

  vec_t tbl [8];

  chipid_arbiter_cache #(
    .SRC_RESET_CYCLES(4),
    .TIMEOUT_CYCLES  (1024)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .src_chip_id   (src_chip_id),
    .src_data_valid(src_data_valid),
    .src_reset     (src_reset),
    .refresh       (refresh),
    .s0_address    (s0_address),
    .s0_read       (s0_read),
    .s0_readdata   (s0_readdata),
    .s0_waitrequest(s0_waitrequest),
    .s1_address    (s1_address),
    .s1_read       (s1_read),
    .s1_readdata   (s1_readdata),
    .s1_waitrequest(s1_waitrequest),
    .id_ready      (id_ready),
    .id_error      (id_error)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Absolute time guard.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Single read on one port at the current negedge; returns at the next negedge.
  task automatic do_read(input int port, input logic [1:0] a, input logic [31:0] exp, input string nm);
    if (port == 0) begin s0_read = 1'b1; s0_address = a; end
    else           begin s1_read = 1'b1; s1_address = a; end
    #1;
    if (port == 0) begin
      chk({nm, " wait0"}, {63'd0, s0_waitrequest}, 64'd0);
      chk({nm, " data0"}, {32'd0, s0_readdata}, {32'd0, exp});
    end else begin
      chk({nm, " wait1"}, {63'd0, s1_waitrequest}, 64'd0);
      chk({nm, " data1"}, {32'd0, s1_readdata}, {32'd0, exp});
    end
    @(negedge clk);
    s0_read = 1'b0;
    s1_read = 1'b0;
  endtask

  task automatic do_refresh();
    refresh = 1'b1;
    @(negedge clk);
    refresh = 1'b0;
  endtask

  // Entered at the negedge where the DUT has just entered RST_SRC.
  // valid_k < 0 means let the acquisition time out.
  task automatic acquire(input int valid_k, input logic [63:0] id, input bit probe);
    int lim;
    lim = (valid_k < 0) ? 1023 : valid_k;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("rst_phase%0d src_reset", c), {63'd0, src_reset}, 64'd1);
      chk($sformatf("rst_phase%0d flags", c), {62'd0, id_error, id_ready}, 64'd0);
      refresh = (c == 1);
      @(negedge clk);
    end
    refresh = 1'b0;
    for (int k = 0; k <= lim; k++) begin
      refresh        = (k == 0);
      src_data_valid = (k == valid_k);
      src_chip_id    = (k == valid_k) ? id : 64'h5A5A_5A5A_5A5A_5A5A;
      if (probe) begin
        s1_read    = 1'b1;
        s1_address = 2'd1;
        s0_read    = (k == 5);
        s0_address = 2'd2;
      end
      #1;
      chk($sformatf("wait%0d src_reset", k), {63'd0, src_reset}, 64'd0);
      chk($sformatf("wait%0d flags", k), {62'd0, id_error, id_ready}, 64'd0);
      if (probe) begin
        chk($sformatf("wait%0d s1 stall", k), {63'd0, s1_waitrequest}, 64'd1);
        chk($sformatf("wait%0d s1 data", k), {32'd0, s1_readdata}, 64'd0);
        if (k == 5) begin
          chk("wait status s0 stall", {63'd0, s0_waitrequest}, 64'd0);
          chk("wait status s0 data", {32'd0, s0_readdata}, 64'd0);
        end
      end
      @(negedge clk);
    end
    refresh        = 1'b0;
    src_data_valid = 1'b0;
    s0_read        = 1'b0;
    #1;
    if (valid_k < 0)
      chk("acq end flags (timeout)", {62'd0, id_error, id_ready}, 64'd2);
    else
      chk("acq end flags (ready)", {62'd0, id_error, id_ready}, 64'd1);
    if (probe) begin
      chk("probe s1 released", {63'd0, s1_waitrequest}, 64'd0);
      chk("probe s1 data", {32'd0, s1_readdata}, {32'd0, id[63:32]});
      @(negedge clk);
      s1_read = 1'b0;
    end
  endtask

  initial begin
    // READY-state arbitration vectors; pointer is "s1 last" when applied.
    tbl[0] = '{1'b1, 2'd0, 1'b1, 2'd0, 32'h89AB_CDEF, 1'b0, 32'h0,         1'b1};
    tbl[1] = '{1'b1, 2'd0, 1'b1, 2'd0, 32'h0,         1'b1, 32'h89AB_CDEF, 1'b0};
    tbl[2] = '{1'b1, 2'd0, 1'b1, 2'd0, 32'h89AB_CDEF, 1'b0, 32'h0,         1'b1};
    tbl[3] = '{1'b1, 2'd0, 1'b1, 2'd0, 32'h0,         1'b1, 32'h89AB_CDEF, 1'b0};
    tbl[4] = '{1'b1, 2'd2, 1'b0, 2'd0, 32'h1,         1'b0, 32'h0,         1'b0};
    tbl[5] = '{1'b0, 2'd0, 1'b0, 2'd1, 32'h0,         1'b0, 32'h0,         1'b0};
    tbl[6] = '{1'b1, 2'd1, 1'b1, 2'd2, 32'h0,         1'b1, 32'h1,         1'b0};
    tbl[7] = '{1'b1, 2'd3, 1'b1, 2'd0, 32'h0,         1'b0, 32'h0,         1'b1};

    reset          = 1'b1;
    src_chip_id    = 64'd0;
    src_data_valid = 1'b0;
    refresh        = 1'b0;
    s0_address     = 2'd0;
    s0_read        = 1'b0;
    s1_address     = 2'd0;
    s1_read        = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state, with stalls still following read && !grant.
    s0_read = 1'b1; s0_address = 2'd0;
    s1_read = 1'b1; s1_address = 2'd2;
    #1;
    chk("reset src_reset", {63'd0, src_reset}, 64'd1);
    chk("reset flags", {62'd0, id_error, id_ready}, 64'd0);
    chk("reset s0 addr0 stall", {63'd0, s0_waitrequest}, 64'd1);
    chk("reset s0 data", {32'd0, s0_readdata}, 64'd0);
    chk("reset s1 status nostall", {63'd0, s1_waitrequest}, 64'd0);
    chk("reset s1 status data", {32'd0, s1_readdata}, 64'd0);
    @(negedge clk);
    s0_read = 1'b0;
    s1_read = 1'b0;
    reset   = 1'b0;

    // First acquisition with reads probing during WAIT_VALID.
    acquire(10, c_ID_A, 1'b1);
    do_read(0, 2'd0, 32'h89AB_CDEF, "A addr0");
    do_read(0, 2'd1, 32'h0123_4567, "A addr1");
    do_read(0, 2'd2, 32'h0000_0001, "A status");
    do_read(0, 2'd3, 32'h0000_0000, "A reserved");
    do_read(1, 2'd3, 32'h0000_0000, "A s1 reserved");

    // Table-driven arbitration in READY.
    for (int i = 0; i < 8; i++) begin
      s0_read = tbl[i].r0; s0_address = tbl[i].a0;
      s1_read = tbl[i].r1; s1_address = tbl[i].a1;
      #1;
      chk($sformatf("vec%0d rd0", i), {32'd0, s0_readdata}, {32'd0, tbl[i].rd0});
      chk($sformatf("vec%0d w0", i), {63'd0, s0_waitrequest}, {63'd0, tbl[i].w0});
      chk($sformatf("vec%0d rd1", i), {32'd0, s1_readdata}, {32'd0, tbl[i].rd1});
      chk($sformatf("vec%0d w1", i), {63'd0, s1_waitrequest}, {63'd0, tbl[i].w1});
      @(negedge clk);
    end
    s0_read = 1'b0;
    s1_read = 1'b0;

    // Refresh concurrent with a granted read: old data returned.
    s0_read = 1'b1; s0_address = 2'd0; refresh = 1'b1;
    #1;
    chk("refresh read stall", {63'd0, s0_waitrequest}, 64'd0);
    chk("refresh read data", {32'd0, s0_readdata}, 64'h89AB_CDEF);
    @(negedge clk);
    s0_read = 1'b0; refresh = 1'b0;
    acquire(2, c_ID_B, 1'b0);
    do_read(0, 2'd0, 32'h1234_5678, "B addr0");
    do_read(0, 2'd1, 32'hFFFF_0000, "B addr1");

    // Timeout into ERROR.
    do_refresh();
    acquire(-1, 64'd0, 1'b0);
    do_read(0, 2'd0, 32'h0, "ERR addr0");
    do_read(0, 2'd1, 32'h0, "ERR addr1");
    do_read(0, 2'd2, 32'h2, "ERR status");

    // Valid on the final timeout cycle wins.
    do_refresh();
    acquire(1023, c_ID_C, 1'b0);
    do_read(0, 2'd0, 32'hCAFE_F00D, "C addr0");
    do_read(1, 2'd1, 32'hDEAD_BEEF, "C addr1");

    // Asynchronous reset in WAIT_VALID cycle 500, then full restart.
    do_refresh();
    repeat (4 + 500) @(negedge clk);
    s0_read = 1'b1; s0_address = 2'd0;
    #1;
    chk("pre-reset src_reset", {63'd0, src_reset}, 64'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async src_reset", {63'd0, src_reset}, 64'd1);
    chk("async flags", {62'd0, id_error, id_ready}, 64'd0);
    chk("async s0 addr0 stall", {63'd0, s0_waitrequest}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    s0_read = 1'b0;
    reset   = 1'b0;
    acquire(-1, 64'd0, 1'b0);
    do_read(0, 2'd1, 32'h0, "post-reset ERR addr1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chipid_arbiter_cache.md
CHIPID_ARBITER_CACHE -- requirements
Module: chipid_arbiter_cache

Interface
REQ-001 SHALL have parameter SRC_RESET_CYCLES, default 4: cycles src_reset is held high per acquisition (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum cycles to wait for src_data_valid (legal range 2..65535).
REQ-003 SHALL have port clk, input, 1: single clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port src_chip_id, input, 64: ID value from the chip-ID source.
REQ-006 SHALL have port src_data_valid, input, 1: source ID valid.
REQ-007 SHALL have port src_reset, output, 1: reset driven to the chip-ID source.
REQ-008 SHALL have port refresh, input, 1: single-cycle re-acquire request.
REQ-009 SHALL have ports s0_address and s1_address, input, 2: 0 = ID[31:0], 1 = ID[63:32], 2 = status, 3 = reserved.
REQ-010 SHALL have ports s0_read and s1_read, input, 1: Avalon-MM read strobes.
REQ-011 SHALL have ports s0_readdata and s1_readdata, output, 32: read data, valid when read && !waitrequest.
REQ-012 SHALL have ports s0_waitrequest and s1_waitrequest, output, 1: Avalon-MM stall.
REQ-013 SHALL have ports id_ready and id_error, output, 1: cached ID valid, and acquisition timed out.

Function
REQ-014 SHALL implement the FSM states RST_SRC, WAIT_VALID, READY and ERROR.
REQ-015 RST_SRC: SHALL hold src_reset=1 for exactly SRC_RESET_CYCLES cycles, then move to WAIT_VALID with the timeout counter at 0.
REQ-016 WAIT_VALID: src_reset=0; the counter increments each cycle.
REQ-017 WAIT_VALID, src_data_valid sampled 1: SHALL latch src_chip_id into the 64-bit cache on that edge and move to READY.
REQ-018 WAIT_VALID, counter reaching TIMEOUT_CYCLES-1 with src_data_valid=0: SHALL move to ERROR and clear the cache to 0.
REQ-019 WAIT_VALID, valid and timeout in the same cycle: valid SHALL win.
REQ-020 READY and ERROR: a refresh pulse SHALL move the FSM to RST_SRC, keep the cache unchanged, and clear id_ready/id_error on entry.
REQ-021 RST_SRC and WAIT_VALID: refresh SHALL be ignored.
REQ-022 id_ready SHALL be 1 exactly in READY, and id_error SHALL be 1 exactly in ERROR; both are registered state decodes.
REQ-023 A slave is "eligible" when its read=1 and either address is 2 or 3, or the state is READY or ERROR.
REQ-024 Arbitration: at most one slave SHALL be granted per cycle.
REQ-025 Single eligible slave: it SHALL be granted.
REQ-026 Both eligible: the slave not granted most recently SHALL be granted, and the round-robin pointer updates on every grant.
REQ-027 waitrequest SHALL be combinational: sN_waitrequest = sN_read && !grantN; it is 0 when read=0.
REQ-028 Read data, combinational from registered state: address 0 gives cache[31:0], address 1 gives cache[63:32], address 2 gives {30'b0, id_error, id_ready}, address 3 gives 0.
REQ-029 ERROR state: reads at addresses 0 and 1 SHALL complete without stall and return 0.
REQ-030 readdata SHALL be 0 whenever it is not granted.
REQ-031 refresh arriving in the same cycle as a granted read: the read SHALL complete with the pre-refresh data.

Reset
REQ-032 Asserting reset SHALL immediately give: state RST_SRC, src_reset=1, the RST_SRC cycle count at 0, cache=0, id_ready=0, id_error=0, round-robin pointer "s1 last" (s0 wins first contention), and the timeout counter at 0.
REQ-033 Reset asserted mid-acquisition or mid-read SHALL abort the operation; on release, a full RST_SRC/WAIT_VALID sequence SHALL restart.
REQ-034 With reset asserted, waitrequest SHALL still follow REQ-027, where state RST_SRC gives stalls for addresses 0 and 1.

Verification
REQ-035 Release reset, src_data_valid=1 at WAIT_VALID cycle 10, src_chip_id=64'h0123_4567_89AB_CDEF -> src_reset high for 4 cycles, id_ready=1 the next cycle, s0 reads addr0/addr1 return 32'h89AB_CDEF/32'h0123_4567 with no stall.
REQ-036 src_data_valid held 0 -> id_error=1 after 4+1024 cycles, addr0 read returns 0 unstalled, addr2 returns 32'h2.
REQ-037 s0 and s1 both reading addr0 in READY for 4 cycles -> grants alternate s0,s1,s0,s1, the loser sees waitrequest=1 and readdata=0.
REQ-038 s1 reads addr1 during WAIT_VALID -> waitrequest held until the cycle id_ready rises, then returns cache[63:32]; an addr2 read in the same period completes immediately with 0.
REQ-039 refresh in READY concurrent with a granted s0 addr0 read -> the read returns the old ID, then src_reset=1 next cycle, id_ready=0, and re-acquisition of the new ID 64'hFFFF_0000_1234_5678 is reflected at addr0/addr1.
REQ-040 Reset asserted at WAIT_VALID cycle 500 -> src_reset=1, cache=0 and id_ready=0 asynchronously; on release, the timeout counter restarts from 0.
